pmem_ctrl: RTL and testbench
============================

# pmem_ctrl

Parametrised single-port synchronous memory with registered read pipeline, per-entry written tracking and selectable read-during-write behaviour. Next generation of the team's 4-bit × 8-entry bench memory, driven through the same simple-bus style signals (wr, rd, addr, wdata, rdata, outp_valid) from a clocking-block testbench. Adds configurable width, depth and read latency, plus an error flag for reads of never-written locations.

## Interface
Parameters:
- DATA_W, 4, data width in bits (1–64)
- ADDR_W, 3, address width; depth = 2**ADDR_W
- RD_LAT, 1, read latency in cycles from rd sample to outp_valid (1–4)
- RDW_MODE, RDW_OLD, read-during-write result for same address: RDW_OLD returns prior content, RDW_NEW returns wdata
- INIT_VAL, 0, value returned for reads of unwritten entries

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- wr  in  1  write strobe
- rd  in  1  read strobe
- addr  in  ADDR_W  shared read/write address
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  read data, meaningful only when outp_valid=1
- outp_valid  out  1  one-cycle pulse per accepted read
- rd_err  out  1  aligned with outp_valid; 1 when read entry was never written since reset

## Operation
- Storage: 2**ADDR_W × DATA_W array plus 2**ADDR_W written bits.
- Write: wr=1 at posedge stores wdata at addr, sets written[addr]. No acknowledge; every write accepted.
- Read: rd=1 at posedge captures array[addr] and written[addr] into pipeline stage 0; result advances one stage per cycle; last stage drives rdata/outp_valid/rd_err.
- Unwritten read: rdata=INIT_VAL, rd_err=1, outp_valid=1.
- rd and wr same cycle, same addr: write always performed. RDW_OLD → read returns previous content and previous written bit. RDW_NEW → returns wdata, rd_err=0.
- rd and wr same cycle, different addr: both performed independently.
- Back-to-back reads: one accepted every cycle; pipeline fully throughput-capable, no stalls, no backpressure.
- Reset: clears all written bits, all pipeline valid bits, rdata, outp_valid, rd_err. Array contents not cleared (observable only as INIT_VAL via written bits). Reads in flight at reset are discarded; no outp_valid for them afterward.
- rd/wr asserted in the reset cycle are ignored.

## Timing
- Reset values: rdata=0, outp_valid=0, rd_err=0.
- rd sampled at edge N → outp_valid=1, rdata, rd_err valid after edge N+RD_LAT−1... stated exactly: RD_LAT=1 means outputs valid in the cycle following the sampling edge (registered output, visible to clocking-block input sample at edge N+1).
- rdata holds last value when outp_valid=0 (no forced zero); outp_valid and rd_err are 0 when no result.
- Write visible to a read at the next edge (RDW_OLD) or same edge (RDW_NEW).
- No combinational path from any input to any output.

## Structure
- Package pmem_pkg: enum rdw_mode_e {RDW_OLD, RDW_NEW}; constant MAX_RD_LAT=4; elaboration-time checks on RD_LAT range and DATA_W range.
- Sub-module pmem_rd_pipe: parametrised delay line (DATA_W+2 bits: valid, err, data; depth RD_LAT) with synchronous clear on rst. Array and written-bit logic stay in pmem_ctrl.

## Test plan
- Reset then read addr 5 → after RD_LAT cycles outp_valid=1, rdata=INIT_VAL, rd_err=1.
- Write 0xA to addr 3, read addr 3 next cycle → rdata=0xA, rd_err=0, outp_valid single-cycle pulse at RD_LAT.
- RD_LAT=3, reads to addr 0..7 every cycle after filling with addr+1 → eight consecutive outp_valid pulses, rdata 1..8 in order, no gaps.
- Write 0x5 to addr 2, then same-cycle wr 0x9 + rd addr 2 → RDW_OLD returns 0x5; RDW_NEW returns 0x9; next read returns 0x9.
- Issue read, assert rst while in flight (RD_LAT=3) → no outp_valid emerges; subsequent read of previously written addr returns INIT_VAL with rd_err=1.
- DATA_W=16, ADDR_W=6: write 0xBEEF to addr 63, read → rdata=0xBEEF; read addr 0 → rd_err=1.

Source files
------------

// File: rtl/pmem_pkg.sv
// Shared types and elaboration-time parameter checks for the pmem_ctrl memory.
package pmem_pkg;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  localparam int MAX_RD_LAT = 4;
  localparam int MAX_DATA_W = 64;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= 1) && (lat <= MAX_RD_LAT);
  endfunction

  function automatic bit data_w_ok(input int w);
    return (w >= 1) && (w <= MAX_DATA_W);
  endfunction

endpackage

// File: rtl/pmem_rd_pipe.sv
// Read-result delay line: valid, error and data advance one stage per clock.
module pmem_rd_pipe #(
  parameter int DATA_W = 4,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_vld,
  input  logic              d_err,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_vld,
  output logic              q_err,
  output logic [DATA_W-1:0] q_data
);

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] err_p;
  logic [DATA_W-1:0] data_p [STAGES];

  // Data only moves with a valid token, so the last stage holds the previous result.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      err_p <= '0;
      for (int i = 0; i < STAGES; i++) data_p[i] <= '0;
    end else begin
      vld_p[0] <= d_vld;
      err_p[0] <= d_vld & d_err;
      if (d_vld) data_p[0] <= d_data;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
        err_p[i] <= err_p[i-1];
        if (vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  assign q_vld  = vld_p[STAGES-1];
  assign q_err  = err_p[STAGES-1];
  assign q_data = data_p[STAGES-1];

endmodule

// File: rtl/pmem_ctrl.sv
// Single-port memory with written-bit tracking, selectable read-during-write
// result and a fixed-latency registered read pipeline.
module pmem_ctrl
  import pmem_pkg::*;
#(
  parameter int                DATA_W   = 4,
  parameter int                ADDR_W   = 3,
  parameter int                RD_LAT   = 1,
  parameter rdw_mode_e         RDW_MODE = RDW_OLD,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              outp_valid,
  output logic              rd_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("pmem_ctrl: RD_LAT must be 1..%0d", MAX_RD_LAT);
  end
  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("pmem_ctrl: DATA_W must be 1..%0d", MAX_DATA_W);
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;
  logic [DATA_W-1:0] rd_data_in;
  logic              rd_err_in;

  // Array contents survive reset; only the written bits are cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     written       <= '0;
    else if (wr) written[addr] <= 1'b1;
  end

  // Address is shared, so a same-cycle rd+wr always targets the same entry.
  always_comb begin
    rd_data_in = INIT_VAL;
    rd_err_in  = 1'b1;
    if ((RDW_MODE == RDW_NEW) && wr) begin
      rd_data_in = wdata;
      rd_err_in  = 1'b0;
    end else if (written[addr]) begin
      rd_data_in = mem[addr];
      rd_err_in  = 1'b0;
    end
  end

  pmem_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (RD_LAT)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .d_vld  (rd),
    .d_err  (rd_err_in),
    .d_data (rd_data_in),
    .q_vld  (outp_valid),
    .q_err  (rd_err),
    .q_data (rdata)
  );

endmodule

// File: tb/tb_pmem_ctrl.sv
// Bench for pmem_ctrl: two configurations driven in lockstep, checked against a queue-based model.
module tb_pmem_ctrl;
  import pmem_pkg::*;

  localparam logic [3:0]  INIT_A = 4'h0;
  localparam logic [15:0] INIT_B = 16'h5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr = 1'b0, rd = 1'b0;
  logic [5:0]  addr = '0;
  logic [15:0] wdata = '0;

  logic [3:0]  rdata_a;
  logic        vld_a, err_a;
  logic [15:0] rdata_b;
  logic        vld_b, err_b;

  always #5 clk = ~clk;

  pmem_ctrl #(
    .DATA_W(4), .ADDR_W(3), .RD_LAT(1), .RDW_MODE(RDW_OLD), .INIT_VAL(INIT_A)
  ) u_dut_a (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr[2:0]), .wdata(wdata[3:0]),
    .rdata(rdata_a), .outp_valid(vld_a), .rd_err(err_a)
  );

  pmem_ctrl #(
    .DATA_W(16), .ADDR_W(6), .RD_LAT(3), .RDW_MODE(RDW_NEW), .INIT_VAL(INIT_B)
  ) u_dut_b (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .outp_valid(vld_b), .rd_err(err_b)
  );

  // Reference model: plain arrays for contents, queues of results with due edge.
  typedef struct {
    int          due;
    logic [63:0] data;
    bit          err;
  } pend_t;

  int          lat   [2] = '{1, 3};
  bit          newm  [2] = '{1'b0, 1'b1};
  int          amask [2] = '{7, 63};
  logic [63:0] dmask [2] = '{64'hF, 64'hFFFF};
  logic [63:0] initv [2] = '{64'(INIT_A), 64'(INIT_B)};

  logic [63:0] mdl_mem [2][64];
  bit          mdl_wrt [2][64];
  logic [63:0] exp_rdata [2] = '{64'd0, 64'd0};
  pend_t       q0[$], q1[$];
  int          edge_n = 0;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h want %0h", tag, edge_n, act, exp);
    end
  endtask

  task automatic model_edge(input int d, input bit r, input bit w, input bit rr,
                            input int a_in, input logic [63:0] dat_in);
    int a;
    logic [63:0] dv;
    pend_t e;
    a  = a_in & amask[d];
    dv = dat_in & dmask[d];
    if (r) begin
      for (int i = 0; i < 64; i++) mdl_wrt[d][i] = 1'b0;
      if (d == 0) q0.delete(); else q1.delete();
      exp_rdata[d] = '0;
    end else begin
      if (rr) begin
        e.due = edge_n + lat[d];
        if (w && newm[d]) begin
          e.data = dv; e.err = 1'b0;
        end else if (mdl_wrt[d][a]) begin
          e.data = mdl_mem[d][a]; e.err = 1'b0;
        end else begin
          e.data = initv[d]; e.err = 1'b1;
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (w) begin
        mdl_mem[d][a] = dv;
        mdl_wrt[d][a] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input int d, input logic [63:0] act_d, input bit act_v, input bit act_e);
    pend_t e;
    bit    have;
    bit    exp_v, exp_e;
    have = 1'b0;
    if (d == 0) begin
      if (q0.size() > 0 && q0[0].due == edge_n) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].due == edge_n) begin e = q1.pop_front(); have = 1'b1; end
    end
    exp_v = have;
    exp_e = have ? e.err : 1'b0;
    if (have) exp_rdata[d] = e.data;
    chk(d == 0 ? "A.outp_valid" : "B.outp_valid", 64'(act_v), 64'(exp_v));
    chk(d == 0 ? "A.rd_err" : "B.rd_err", 64'(act_e), 64'(exp_e));
    chk(d == 0 ? "A.rdata" : "B.rdata", act_d, exp_rdata[d]);
  endtask

  // Drive one cycle at the falling edge, advance the model, then check after the edge.
  task automatic step(input bit r, input bit w, input bit rr, input int a, input logic [63:0] dat);
    rst   = r;
    wr    = w;
    rd    = rr;
    addr  = 6'(a);
    wdata = dat[15:0];
    model_edge(0, r, w, rr, a, dat);
    model_edge(1, r, w, rr, a, dat);
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    check_outputs(0, 64'(rdata_a), vld_a, err_a);
    check_outputs(1, 64'(rdata_b), vld_b, err_b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 64'd0);
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 0, 64'd0);
    step(1'b1, 1'b1, 1'b1, 5, 64'h3);

    // Unwritten read returns INIT_VAL with error.
    step(1'b0, 1'b0, 1'b1, 5, 64'd0);
    idle(4);

    // Write then read next cycle.
    step(1'b0, 1'b1, 1'b0, 3, 64'hA);
    step(1'b0, 1'b0, 1'b1, 3, 64'd0);
    idle(4);

    // Fill 0..7 with addr+1, then back-to-back reads.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, i, 64'(i + 1));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, i, 64'd0);
    idle(4);

    // Read-during-write on the same entry.
    step(1'b0, 1'b1, 1'b0, 2, 64'h5);
    step(1'b0, 1'b1, 1'b1, 2, 64'h9);
    step(1'b0, 1'b0, 1'b1, 2, 64'd0);
    idle(4);

    // Reset while reads are in flight.
    step(1'b0, 1'b1, 1'b0, 4, 64'h7);
    step(1'b0, 1'b0, 1'b1, 4, 64'd0);
    step(1'b1, 1'b0, 1'b0, 0, 64'd0);
    idle(4);
    step(1'b0, 1'b0, 1'b1, 4, 64'd0);
    idle(4);

    // Top address and wide data.
    step(1'b0, 1'b1, 1'b0, 63, 64'hBEEF);
    step(1'b0, 1'b0, 1'b1, 63, 64'd0);
    step(1'b0, 1'b0, 1'b1, 0, 64'd0);
    idle(4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 63)), 64'($urandom));
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
